i2s_tx: RTL and testbench
=========================

# i2s_tx

Stereo I2S transmitter and sample-clock generator that sits downstream of the `karplus_strong` voices and the mixer. It derives BCLK, LRCK and serial data from the system clock and frames one 16-bit left/right pair per audio frame. It also drives `clk_sample`, which steps every upstream voice once per frame, so synthesis and output stay locked to the same sample rate. Input words are captured only at frame boundaries, with optional attenuation, mute and mono folding.

## Interface
- `BCLK_DIV`, default 8: clk cycles per BCLK half-period; must be ≥1.
- `SLOT_W`, default 32: BCLK periods per channel slot; must be ≥17.
- `clk` input, 1 bit: system clock.
- `aclr_n` input, 1 bit: asynchronous active-low reset.
- `sample_l` input, 16 bits: left word, two's complement.
- `sample_r` input, 16 bits: right word, two's complement.
- `attn` input, 3 bits: arithmetic right-shift applied to both channels, 0..7.
- `mute` input, 1 bit: transmit zeros.
- `mono` input, 1 bit: right slot carries the processed `sample_l`.
- `bclk` output, 1 bit: I2S bit clock.
- `lrck` output, 1 bit: word select; 0 = left, 1 = right.
- `sdata` output, 1 bit: serial data, MSB first.
- `clk_sample` output, 1 bit: sample-rate square wave to the voices; equals `lrck`.
- `frame_start` output, 1 bit: one-clk pulse at each frame boundary.

## Operation
- **Divider.** `div_cnt` counts 0..BCLK_DIV-1. When it reaches BCLK_DIV-1 it wraps to 0 and `bclk` toggles.
- **BCLK fall event.** The cycle in which `bclk` toggles 1→0 is a "fall". All serial outputs update only on a fall.
- **Bit counter.** `bit_cnt` counts 0..2·SLOT_W-1 and advances by 1 on each fall, wrapping to 0.
- Let `p = bit_cnt mod SLOT_W`.
- **Word select.** `lrck` is registered as (new `bit_cnt` ≥ SLOT_W). It changes on the fall where `bit_cnt` becomes 0 or SLOT_W.
- **Data.** `sdata` for new p in 1..16 is bit (16-p) of that slot's transmit word. It is 0 for p = 0 and for p in 17..SLOT_W-1. This gives standard I2S: MSB one BCLK after the LRCK edge, zero padding afterwards.
- **Frame boundary.** This is the fall where `bit_cnt` wraps 2·SLOT_W-1 → 0. On that fall:
  - The left shift register loads `mute ? 0 : sample_l >>> attn`.
  - The right shift register loads `mute ? 0 : (mono ? sample_l : sample_r) >>> attn`.
  - `attn`, `mute`, `mono` and both samples are sampled only in this cycle. Changes mid-frame never alter the frame in flight.
- **Shift rule.** A word shifts left one bit per fall during its p = 1..16. The right word is untouched during the left slot.
- **Attenuation** is sign-preserving. Example: 16'h8000 >>> 3 = 16'hF000.
- **Upstream handshake.** `clk_sample` rises at the start of the right slot. This leaves SLOT_W·2·BCLK_DIV clk cycles (512 at defaults) for the voices and mixer to settle before the next boundary capture. Upstream must present stable samples by then. No ready/valid signalling exists.
- **Frame rate** is clk / (4·BCLK_DIV·SLOT_W), i.e. clk/1024 at defaults (48.83 kHz at 50 MHz).

## Timing
- **Reset (`aclr_n` low, asynchronous).**
  - `bclk`, `lrck`, `clk_sample`, `sdata` and `frame_start` are all 0.
  - `div_cnt` and `bit_cnt` are 0, and both shift registers are 0.
  - Reset mid-frame aborts the frame immediately. No partial word is resumed.
- **After reset release (cycle 0 = first clk edge with `aclr_n` high):**
  - `bclk` first rises at the end of cycle BCLK_DIV-1 and first falls at the end of cycle 2·BCLK_DIV-1.
  - The first frame after reset transmits all-zero words.
  - The first boundary occurs after 2·SLOT_W falls, at clk edge 4·BCLK_DIV·SLOT_W (1024 at defaults). Inputs are captured there.
- **Output registers.** All outputs are registered, with zero combinational paths from inputs. `sdata` and `lrck` change in the same clk cycle as the falling `bclk`.
- **`frame_start`** is high for exactly the one clk cycle in which `bit_cnt` reads 0 after a wrap. It is not asserted out of reset.
- **BCLK_DIV = 1:** `bclk` toggles every clk, and a fall occurs every 2nd clk.

## Test plan
- **Reset and first frame.** Defaults, hold `aclr_n` low, then release with `sample_l` = 16'h0000 → all outputs 0 during reset; `bclk` period 16 clk; `lrck` rises at cycle ~512; first `frame_start` at cycle 1024; first frame `sdata` all zero.
- **Basic framing.** `sample_l` = 16'hA5C3, `sample_r` = 16'h1234, `attn` 0 → frame 2 serialises 1010_0101_1100_0011 on p = 1..16 of the left slot, then 0001_0010_0011_0100 on the right slot; padding bits 0; bit sampled on `bclk` rising edge.
- **Attenuation, mute, mono.** `sample_l` = 16'h8000, `attn` = 3 → left word 16'hF000. `mono` = 1 with `sample_r` = 16'h7FFF → right word equals left. `mute` = 1 → both words 0 from the next boundary.
- **Mid-frame input change.** Change `sample_l`, `attn` and `mute` at cycle boundary+300 → current frame unchanged; new values appear only in the following frame.
- **Reset mid-frame.** Assert `aclr_n` low during right-slot bit 8 → outputs 0 within the same cycle (asynchronous); after release, the timing from the reset test repeats exactly.
- **Parameter corner.** `BCLK_DIV` = 1, `SLOT_W` = 17 → `bclk` = clk/2; frame = 68 clk; no padding bits; MSB one BCLK after each `lrck` edge; `clk_sample` period 68 clk.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S transmitter and frame-locked sample-clock generator
// clk, aclr_n: system clock and asynchronous active-low reset
// sample_l, sample_r, attn, mute, mono: frame inputs, sampled only at the frame boundary
// bclk, lrck, sdata: I2S bus; clk_sample: copy of lrck that steps the upstream voices
// frame_start: one-clk pulse in the cycle after each frame boundary
module i2s_tx #(
  parameter int BCLK_DIV = 8,
  parameter int SLOT_W = 32
) (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic [2:0]  attn,
  input  logic        mute,
  input  logic        mono,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        clk_sample,
  output logic        frame_start
);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_W);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, bit_nx, p_nx;
  logic [15:0] sh_l, sh_r, word_l, word_r;
  logic tick, fall, wrap, in_r, active;
  always_comb begin
    tick = div_cnt == DW'(BCLK_DIV - 1);
    fall = tick && bclk;
    wrap = bit_cnt == BW'(2 * SLOT_W - 1);
    bit_nx = wrap ? '0 : bit_cnt + 1'b1;
    in_r = bit_nx >= BW'(SLOT_W);
    p_nx = in_r ? bit_nx - BW'(SLOT_W) : bit_nx;
    active = p_nx >= BW'(1) && p_nx <= BW'(16);
    word_l = mute ? '0 : 16'($signed(sample_l) >>> attn);
    word_r = mute ? '0 : 16'($signed(mono ? sample_l : sample_r) >>> attn);
  end
  assign clk_sample = lrck;
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk <= 1'b0;
      lrck <= 1'b0;
      sdata <= 1'b0;
      frame_start <= 1'b0;
      sh_l <= '0;
      sh_r <= '0;
    end else begin
      frame_start <= fall && wrap;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) bclk <= !bclk;
      if (fall) begin
        bit_cnt <= bit_nx;
        lrck <= in_r;
        sdata <= active && (in_r ? sh_r[15] : sh_l[15]);
        if (wrap) begin
          sh_l <= word_l;
          sh_r <= word_r;
        end else if (active && in_r) sh_r <= sh_r << 1;
        else if (active) sh_l <= sh_l << 1;
      end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized and directed checks of i2s_tx against a time-arithmetic model
module tb_i2s_tx;
  logic clk = 1'b0;
  logic aclr_n = 1'b0;
  logic [15:0] sample_l, sample_r;
  logic [2:0] attn;
  logic mute, mono;
  int checks = 0;
  int errors = 0;
  int nprint = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] att(logic [15:0] s, logic [2:0] a, logic m);
    int v = int'($signed(s));
    int d = 1 << a;
    int q = v / d;
    if (v < 0 && v % d != 0) q = q - 1;
    return m ? 16'h0 : 16'(q);
  endfunction

  // Outputs after clk edge e (e = 0 is the first edge after release), from elapsed time alone.
  function automatic logic [4:0] model(int e, int bd, int sw, logic [15:0] wl, logic [15:0] wr);
    int k = e + 1;
    int n = k / (2 * bd);
    int bc = n % (2 * sw);
    int p = bc % sw;
    logic lr = bc >= sw;
    logic [15:0] w = lr ? wr : wl;
    logic sd = (p >= 1 && p <= 16) ? w[16 - p] : 1'b0;
    return {1'((k / bd) % 2), lr, sd, lr, 1'(k % (4 * bd * sw) == 0)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int BD = g == 0 ? 8 : 1;
    localparam int SW = g == 0 ? 32 : 17;
    logic bclk, lrck, sdata, clk_sample, frame_start;
    int e = -1;
    logic [15:0] wl = '0;
    logic [15:0] wr = '0;
    logic [4:0] got, want;
    i2s_tx #(.BCLK_DIV(BD), .SLOT_W(SW)) dut (
      .clk(clk), .aclr_n(aclr_n), .sample_l(sample_l), .sample_r(sample_r),
      .attn(attn), .mute(mute), .mono(mono), .bclk(bclk), .lrck(lrck),
      .sdata(sdata), .clk_sample(clk_sample), .frame_start(frame_start)
    );
    always @(posedge clk) begin
      if (!aclr_n) begin
        e = -1;
        wl = '0;
        wr = '0;
      end else begin
        e++;
        if ((e + 1) % (4 * BD * SW) == 0) begin
          wl = att(sample_l, attn, mute);
          wr = att(mono ? sample_l : sample_r, attn, mute);
        end
      end
      #1;
      got = {bclk, lrck, sdata, clk_sample, frame_start};
      want = e < 0 ? 5'b0 : model(e, BD, SW, wl, wr);
      checks++;
      if (got !== want) begin
        errors++;
        if (nprint < 20) $display("FAIL cycle_model inst%0d edge %0d: got %b expected %b", g, e, got, want);
        nprint++;
      end
    end
  end

  // Deserialise the default instance as a receiver would: sample sdata on rising bclk.
  int idx = -1;
  logic prev = 1'b0;
  logic [15:0] acc = '0;
  logic [15:0] obs_l = '0;
  logic [31:0] obs_q[$];
  always @(negedge aclr_n) begin
    idx = -1;
    prev = 1'b0;
  end
  always @(posedge u[0].bclk) begin
    #1;
    if (u[0].lrck != prev) idx = 0;
    else idx++;
    prev = u[0].lrck;
    if (idx >= 1 && idx <= 16) acc = {acc[14:0], u[0].sdata};
    if (idx == 16 && !prev) obs_l = acc;
    if (idx == 16 && prev) obs_q.push_back({obs_l, acc});
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!u[0].frame_start && n < 3000);
  endtask

  task automatic next_rise(output int n);
    logic pv = u[1].clk_sample;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!pv && u[1].clk_sample) return;
      pv = u[1].clk_sample;
    end while (n < 200);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] fx[5] = '{32'h0, 32'hA5C31234, 32'hF0000FFF, 32'hF000F000, 32'h0};
    sample_l = 16'hA5C3;
    sample_r = 16'h1234;
    attn = 3'd0;
    mute = 1'b0;
    mono = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_outs0", {u[0].bclk, u[0].lrck, u[0].sdata, u[0].clk_sample, u[0].frame_start}, 0);
    chk("reset_outs1", {u[1].bclk, u[1].lrck, u[1].sdata, u[1].clk_sample, u[1].frame_start}, 0);
    aclr_n = 1'b1;
    wait_fs(n);
    chk("first_frame_start", n, 1024);
    repeat (300) @(negedge clk);
    sample_l = 16'h8000;
    sample_r = 16'h7FFF;
    attn = 3'd3;
    wait_fs(n);
    chk("frame_period", n, 724);
    repeat (300) @(negedge clk);
    mono = 1'b1;
    wait_fs(n);
    chk("frame_period_mono", n, 724);
    repeat (300) @(negedge clk);
    mute = 1'b1;
    wait_fs(n);
    repeat (300) @(negedge clk);
    mute = 1'b0;
    mono = 1'b0;
    wait_fs(n);
    chk("frames_seen", obs_q.size(), 5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++) chk($sformatf("frame%0d_words", i + 1), obs_q[i], fx[i]);
    for (int i = 0; i < 4; i++) begin
      repeat (300) @(negedge clk);
      sample_l = 16'($urandom);
      sample_r = 16'($urandom);
      attn = 3'($urandom_range(0, 7));
      mute = $urandom_range(0, 3) == 0;
      mono = 1'($urandom);
      wait_fs(n);
      chk("frame_period_rand", n, 724);
    end
    next_rise(n);
    next_rise(n);
    chk("clk_sample_period_small", n, 68);
    n = 0;
    while (!u[0].lrck && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("right_slot_reached", u[0].lrck, 1);
    repeat (8 * 16 + 4) @(negedge clk);
    aclr_n = 1'b0;
    #1;
    chk("async_reset_outs", {u[0].bclk, u[0].lrck, u[0].sdata, u[0].clk_sample, u[0].frame_start}, 0);
    repeat (5) @(negedge clk);
    aclr_n = 1'b1;
    wait_fs(n);
    chk("first_frame_start_again", n, 1024);
    repeat (100) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
